// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR bus: edge-triggered read/write requests,
// programmable wait states, one-cycle completion and rejection pulses.
module memory_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  MDR_read,
    input  logic                  RAM_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  req_collision
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state;
    logic                    rd_q;
    logic                    wr_q;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    op_write;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic rd_rise;
    logic wr_rise;
    logic any_rise;
    logic mem_we;

    // History registers clear to 0, so a level already high at reset release reads as an edge.
    assign rd_rise  = MDR_read & ~rd_q;
    assign wr_rise  = RAM_write & ~wr_q;
    assign any_rise = rd_rise | wr_rise;
    assign mem_we   = (state == ACCESS) && (cnt == 4'd0) && op_write;

    // NOTE: the RAM array sits in its own unreset process; clearing it would defeat RAM
    // inference, and the state reset alone is enough to stop a pending write committing.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    // NOTE: every register below uses non-blocking assignment so each branch reads
    // pre-edge values, regardless of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            cnt           <= 4'd0;
            addr_q        <= '0;
            data_q        <= '0;
            op_write      <= 1'b0;
            data_out      <= '0;
            mem_ready     <= 1'b0;
            busy          <= 1'b0;
            req_collision <= 1'b0;
        end else begin
            rd_q          <= MDR_read;
            wr_q          <= RAM_write;
            req_collision <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_rise && wr_rise) begin
                        req_collision <= 1'b1;
                    end else if (any_rise) begin
                        addr_q   <= address;
                        op_write <= wr_rise;
                        if (wr_rise) begin
                            data_q <= data_in;
                        end
                        cnt   <= 4'(WAIT_STATES);
                        busy  <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // No queueing: any new request during a transfer is rejected.
                    if (any_rise) begin
                        req_collision <= 1'b1;
                    end
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_write) begin
                            data_out <= mem[addr_q];
                        end
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (any_rise) begin
                        req_collision <= 1'b1;
                    end
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder: latency, collisions, reset abort,
// and a zero-wait-state instance.
module tb_memory_responder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;

    logic [8:0]  address   = '0;
    logic        MDR_read  = 1'b0;
    logic        RAM_write = 1'b0;
    logic [31:0] data_in   = '0;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        busy;
    logic        req_collision;

    logic [8:0]  address0   = '0;
    logic        MDR_read0  = 1'b0;
    logic        RAM_write0 = 1'b0;
    logic [31:0] data_in0   = '0;
    logic [31:0] data_out0;
    logic        mem_ready0;
    logic        busy0;
    logic        req_collision0;

    int passed = 0;
    int total  = 0;

    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut (
        .Clock(Clock), .Reset(Reset), .address(address), .MDR_read(MDR_read),
        .RAM_write(RAM_write), .data_in(data_in), .data_out(data_out),
        .mem_ready(mem_ready), .busy(busy), .req_collision(req_collision)
    );

    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .address(address0), .MDR_read(MDR_read0),
        .RAM_write(RAM_write0), .data_in(data_in0), .data_out(data_out0),
        .mem_ready(mem_ready0), .busy(busy0), .req_collision(req_collision0)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Advance one rising edge, then settle on the following falling edge.
    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d);
        address   = a;
        data_in   = d;
        RAM_write = 1'b1;
        cyc();
        RAM_write = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic do_read(input string tag, input logic [8:0] a, input logic [31:0] expected);
        address  = a;
        MDR_read = 1'b1;
        cyc();
        MDR_read = 1'b0;
        repeat (3) cyc();
        check({tag, "_ready"}, 32'(mem_ready), 32'd1);
        check({tag, "_data"}, data_out, expected);
        cyc();
    endtask

    initial begin
        int pulses;

        // 1: asynchronous reset before any clock edge
        #3 Reset = 1'b1;
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_collision", 32'(req_collision), 32'd0);
        @(negedge Clock);
        cyc();
        Reset = 1'b0;
        cyc();

        // 2: write with mid-op operand changes, latency and busy window
        address   = 9'h005;
        data_in   = 32'hDEADBEEF;
        RAM_write = 1'b1;
        cyc();
        check("wr_e0_busy", 32'(busy), 32'd1);
        check("wr_e0_ready", 32'(mem_ready), 32'd0);
        address   = 9'h007;
        data_in   = 32'h0;
        RAM_write = 1'b0;
        cyc();
        check("wr_e1_ready", 32'(mem_ready), 32'd0);
        cyc();
        check("wr_e2_ready", 32'(mem_ready), 32'd0);
        check("wr_e2_busy", 32'(busy), 32'd1);
        cyc();
        check("wr_e3_ready", 32'(mem_ready), 32'd1);
        check("wr_e3_busy", 32'(busy), 32'd1);
        check("wr_e3_data_out", data_out, 32'h0);
        cyc();
        check("wr_e4_ready", 32'(mem_ready), 32'd0);
        check("wr_e4_busy", 32'(busy), 32'd0);

        // 3: read back, data appears with mem_ready three edges after acceptance
        address  = 9'h005;
        MDR_read = 1'b1;
        cyc();
        check("rd_e0_busy", 32'(busy), 32'd1);
        MDR_read = 1'b0;
        cyc();
        cyc();
        check("rd_e2_ready", 32'(mem_ready), 32'd0);
        check("rd_e2_data", data_out, 32'h0);
        cyc();
        check("rd_e3_ready", 32'(mem_ready), 32'd1);
        check("rd_e3_data", data_out, 32'hDEADBEEF);
        cyc();
        check("rd_e4_ready", 32'(mem_ready), 32'd0);
        check("rd_e4_data_hold", data_out, 32'hDEADBEEF);

        // 4: simultaneous read and write edges are both rejected
        address   = 9'h005;
        data_in   = 32'h12345678;
        MDR_read  = 1'b1;
        RAM_write = 1'b1;
        cyc();
        check("col_pulse", 32'(req_collision), 32'd1);
        check("col_busy", 32'(busy), 32'd0);
        cyc();
        check("col_pulse_end", 32'(req_collision), 32'd0);
        check("col_busy_after", 32'(busy), 32'd0);
        MDR_read  = 1'b0;
        RAM_write = 1'b0;
        cyc();
        do_read("col_readback", 9'h005, 32'hDEADBEEF);

        // 5: second write edge while busy is dropped
        address   = 9'h020;
        data_in   = 32'h0AAA5555;
        RAM_write = 1'b1;
        cyc();
        pulses    = 0;
        RAM_write = 1'b0;
        cyc();
        address   = 9'h021;
        data_in   = 32'h99999999;
        RAM_write = 1'b1;
        cyc();
        check("busy_col_pulse", 32'(req_collision), 32'd1);
        RAM_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_ready) pulses++;
            cyc();
        end
        check("busy_col_one_ready", 32'(pulses), 32'd1);
        check("busy_col_idle", 32'(busy), 32'd0);
        do_read("busy_col_readback", 9'h020, 32'h0AAA5555);

        // 6: reset mid-write aborts the commit and clears data_out
        do_write(9'h010, 32'h11110000);
        do_read("pre_abort", 9'h010, 32'h11110000);
        address   = 9'h010;
        data_in   = 32'hCAFEF00D;
        RAM_write = 1'b1;
        cyc();
        RAM_write = 1'b0;
        cyc();
        Reset = 1'b1;
        #1;
        check("abort_data_out", data_out, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        #1 Reset = 1'b0;
        cyc();
        cyc();
        do_read("abort_readback", 9'h010, 32'h11110000);

        // zero wait states: mem_ready between edges k+1 and k+2
        address0   = 9'h003;
        data_in0   = 32'h00000055;
        RAM_write0 = 1'b1;
        cyc();
        check("ws0_wr_e0_busy", 32'(busy0), 32'd1);
        check("ws0_wr_e0_ready", 32'(mem_ready0), 32'd0);
        RAM_write0 = 1'b0;
        cyc();
        check("ws0_wr_e1_ready", 32'(mem_ready0), 32'd1);
        cyc();
        check("ws0_wr_e2_ready", 32'(mem_ready0), 32'd0);
        check("ws0_wr_e2_busy", 32'(busy0), 32'd0);
        MDR_read0 = 1'b1;
        cyc();
        MDR_read0 = 1'b0;
        cyc();
        check("ws0_rd_e1_ready", 32'(mem_ready0), 32'd1);
        check("ws0_rd_e1_data", data_out0, 32'h00000055);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary line");
        $fatal(1, "timeout");
    end

endmodule
